button_event_scheduler: RTL
===========================

# button_event_scheduler

Collects the single-cycle pulses produced by up to N per-button processing units and serialises them into one event stream for a consumer such as a menu FSM or display controller. Each button keeps a small pending-press counter, so presses arriving while the consumer is busy are not lost. Buttons are granted round-robin through a valid/ready handshake. A programmable hold-off gap after every accepted event rate-limits the stream.

## Interface
- N, 4: number of button inputs; power of two, 2..8; IW = $clog2(N).
- sim, 0: hold-off select. Hold-off is HOLD = 3 cycles when sim=1 and 500000 cycles when sim=0. The counter is 19 bits wide.

- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- PulseIn  input  N  one-clk-wide press pulses, already synchronous to clk, one bit per button.
- EventReady  input  1  consumer accepts the current event when high together with EventValid.
- ClearOvf  input  1  synchronous clear of Overflow.
- EventValid  output  1  an event is offered on EventId.
- EventId  output  IW  index of the button being offered.
- PendingAny  output  1  OR over all buttons of (count != 0).
- Overflow  output  1  sticky flag: at least one press was dropped.

## Operation
- Per-button state is a 2-bit pending count cnt[i], saturating at 3. Each edge updates it as follows:
  - inc = PulseIn[i]
  - dec = accept and EventId == i, where accept = EventValid & EventReady
  - inc & dec: unchanged
  - inc only: +1 if cnt < 3; otherwise unchanged and Overflow set
  - dec only: -1
- FSM states are IDLE, OFFER and HOLD.
  - IDLE: if any cnt != 0, pick the first nonzero index scanning ptr, ptr+1, … (mod N). Latch it into EventId and go to OFFER. Otherwise stay in IDLE.
  - OFFER: EventValid = 1 and EventId is held stable. On accept:
    - decrement the granted count (see above)
    - ptr <= EventId + 1 (mod N)
    - timer <= HOLD - 1
    - go to HOLD
    - Without EventReady, stay in OFFER indefinitely. The offer is never withdrawn or re-arbitrated.
  - HOLD: timer decrements each edge. On the edge where timer == 0, go to IDLE.
- Arbitration uses registered counts only. A pulse arriving in the same cycle as the IDLE decision is considered on the next IDLE cycle.
- Overflow and ClearOvf:
  - Overflow is set by any dropped press and cleared by ClearOvf.
  - If a set and ClearOvf occur on the same edge, the set wins.
- PendingAny is combinational from the counts. It includes the count of the button currently being offered.
- Reset values: all cnt = 0, ptr = 0, state IDLE, timer = 0, EventValid = 0, EventId = 0, Overflow = 0.
  - A reset asserted mid-OFFER or mid-HOLD drops all pending presses.
  - After reset release, the first edge is evaluated as IDLE.

## Timing
- Pulse sampled at edge k: cnt nonzero after k; IDLE selects at edge k+1; EventValid high after edge k+1. Latency is 2 clocks from an idle state.
- Accept at edge a: EventValid low after a. HOLD occupies edges a+1 … a+HOLD. IDLE selects at a+HOLD+1 and EventValid rises again after it.
  - Minimum low gap between events is HOLD+1 cycles (4 cycles with sim=1).
- EventValid and EventId are registered. No combinational path exists from EventReady or PulseIn to EventValid or EventId.
- A pulse to the granted button on the accept edge leaves its count unchanged. That button re-competes after HOLD, with its ptr position now behind the other buttons.

## Test plan
- Reset and single press (sim=1, N=4): reset high, release, PulseIn=0010 at edge 5, EventReady=1 → EventValid high after edge 6 with EventId=1 for exactly 1 cycle. PendingAny is 1 after edge 5 and 0 after edge 7. Overflow stays 0.
- Round-robin: pulse 1111 in one cycle, EventReady held 1 → EventIds 0,1,2,3 in order, each EventValid pulse separated by 4 low cycles. PendingAny falls after the fourth accept.
- Backpressure: pulse button 2, EventReady=0 for 10 cycles → EventValid stays high and EventId stays 2 throughout. Raising EventReady produces one accept and then HOLD.
- Saturation/overflow: 4 pulses on button 3 while EventReady=0 → cnt[3]=3 and Overflow=1 after the 4th pulse. Then ClearOvf pulse together with a 5th pulse → Overflow remains 1. ClearOvf alone → Overflow 0. Releasing EventReady yields exactly three events with EventId=3.
- Simultaneous inc/dec: button 0 has cnt=1 and is offered; pulse button 0 on the accept edge → after HOLD a second event with EventId=0 appears, and no third event follows.
- Reset mid-operation: 3 pending presses, assert reset during HOLD → all outputs 0 immediately. After release with no pulses, EventValid stays 0 for 20 cycles.

Source files
------------

// File: rtl/button_event_scheduler.sv
// Serialises per-button press pulses into one round-robin event stream with saturating
// pending counters, a valid/ready handshake and a fixed hold-off gap after each accepted event.
module button_event_scheduler #(
  parameter int N   = 4,
  parameter bit sim = 1'b0,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  PulseIn,
  input  logic          EventReady,
  input  logic          ClearOvf,
  output logic          EventValid,
  output logic [IW-1:0] EventId,
  output logic          PendingAny,
  output logic          Overflow
);

  localparam logic [18:0] HOLD_M1 = sim ? 19'd2 : 19'd499999;

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_HOLD} state_t;

  state_t              r_state, w_state_nxt;
  logic [N-1:0][1:0]   r_cnt, w_cnt_nxt;
  logic [IW-1:0]       r_ptr, w_ptr_nxt;
  logic [IW-1:0]       r_id, w_id_nxt;
  logic [18:0]         r_timer, w_timer_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic                w_ovf_set;
  logic                w_accept;
  logic                w_found;
  logic [IW-1:0]       w_pick;

  assign EventValid = (r_state == S_OFFER);
  assign EventId    = r_id;
  assign Overflow   = r_ovf;
  assign w_accept   = EventValid & EventReady;

  // Scan downwards so the index closest to r_ptr (lowest offset) wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (r_cnt[r_ptr + IW'(k)] != 2'd0) begin
        w_found = 1'b1;
        w_pick  = r_ptr + IW'(k);
      end
    end
  end

  always_comb begin
    w_ovf_set  = 1'b0;
    PendingAny = 1'b0;
    w_cnt_nxt  = r_cnt;
    for (int i = 0; i < N; i++) begin
      PendingAny = PendingAny | (r_cnt[i] != 2'd0);
      if (PulseIn[i] && !(w_accept && (r_id == IW'(i)))) begin
        if (r_cnt[i] == 2'd3) begin
          w_ovf_set = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 2'd1;
        end
      end else if (!PulseIn[i] && w_accept && (r_id == IW'(i))) begin
        w_cnt_nxt[i] = r_cnt[i] - 2'd1;
      end
    end
    // A drop on the same edge as a clear request keeps the flag set.
    w_ovf_nxt = w_ovf_set ? 1'b1 : (ClearOvf ? 1'b0 : r_ovf);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    w_timer_nxt = r_timer;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_id_nxt    = w_pick;
          w_state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        if (w_accept) begin
          w_ptr_nxt   = r_id + IW'(1);
          w_timer_nxt = HOLD_M1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_timer == 19'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - 19'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_timer <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_id_nxt;
      r_timer <= w_timer_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule
